// File: rtl/encoder_step_sequencer.sv
// Step-pulse sequencer for the quadrature encoder: turns a (dir, count, period) command into
// a train of one-cycle horario/antihorario requests with abort and completion reporting.
module encoder_step_sequencer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  output logic             horario,
  output logic             antihorario,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_done
);

  typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic [PER_W-1:0]   gap_q, gap_d;
  logic               aborted_q, aborted_d;
  logic               horario_q, antihorario_q, busy_q, done_q, cmd_ready_q;
  logic [PER_W-1:0]   gap_load;
  logic               last_pulse;

  // GAP lasts P-1 cycles with P = max(period, 2); counter runs P-2 down to 0.
  always_comb begin
    gap_load = (period_q < PER_W'(2)) ? '0 : period_q - PER_W'(2);
  end

  always_comb begin
    last_pulse = ((steps_q + CNT_W'(1)) == count_q);
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    count_d   = count_q;
    period_d  = period_q;
    steps_d   = steps_q;
    gap_d     = gap_q;
    aborted_d = aborted_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          dir_d     = cmd_dir;
          count_d   = cmd_count;
          period_d  = cmd_period;
          steps_d   = '0;
          gap_d     = '0;
          aborted_d = 1'b0;
          state_d   = (cmd_count != '0) ? StPulse : StDone;
        end
      end
      StPulse: begin
        // The pulse driven this cycle always counts, even when aborting.
        steps_d = steps_q + CNT_W'(1);
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (last_pulse) begin
          state_d = StDone;
        end else begin
          gap_d   = gap_load;
          state_d = StGap;
        end
      end
      StGap: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (gap_q == '0) begin
          state_d = StPulse;
        end else begin
          gap_d = gap_q - PER_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered alongside the state so they are glitch-free Moore signals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      dir_q         <= 1'b0;
      count_q       <= '0;
      period_q      <= '0;
      steps_q       <= '0;
      gap_q         <= '0;
      aborted_q     <= 1'b0;
      horario_q     <= 1'b0;
      antihorario_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      count_q       <= count_d;
      period_q      <= period_d;
      steps_q       <= steps_d;
      gap_q         <= gap_d;
      aborted_q     <= aborted_d;
      horario_q     <= (state_d == StPulse) && !dir_d;
      antihorario_q <= (state_d == StPulse) && dir_d;
      busy_q        <= (state_d == StPulse) || (state_d == StGap);
      done_q        <= (state_d == StDone);
      cmd_ready_q   <= (state_d == StIdle);
    end
  end

  assign horario     = horario_q;
  assign antihorario = antihorario_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cmd_ready   = cmd_ready_q;
  assign aborted     = aborted_q;
  assign steps_done  = steps_q;

endmodule

// File: tb/tb_encoder_step_sequencer.sv
// Directed bench for encoder_step_sequencer: a vector table of whole commands checked
// cycle by cycle, plus hand sequences for busy-time commands, idle abort and mid-command reset.
module tb_encoder_step_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [7:0]  cmd_count;
  logic [15:0] cmd_period;
  logic        abort;
  logic        horario;
  logic        antihorario;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  steps_done;

  int n_cmp;
  int n_fail;

  encoder_step_sequencer #(
    .CNT_W(8),
    .PER_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_count  (cmd_count),
    .cmd_period (cmd_period),
    .abort      (abort),
    .horario    (horario),
    .antihorario(antihorario),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .steps_done (steps_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dir;
    logic [7:0]  count;
    logic [15:0] period;
    int          abort_at;  // cycle after accept during which abort is high, 0 = never
    int          done_cyc;  // cycle after accept in which done is expected
    logic [7:0]  steps;
    logic        ab;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_cmd(input logic dir, input logic [7:0] cnt, input logic [15:0] per);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_count  = cnt;
    cmd_period = per;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {h, a, busy, done, ready, aborted}
    logic [5:0] exp_o;
    int         eff;
    int         h_cnt;
    int         a_cnt;

    vecs[0] = '{dir: 1'b0, count: 8'd3, period: 16'd4, abort_at: 0, done_cyc: 10, steps: 8'd3,
                ab: 1'b0};
    vecs[1] = '{dir: 1'b1, count: 8'd2, period: 16'd0, abort_at: 0, done_cyc: 4, steps: 8'd2,
                ab: 1'b0};
    vecs[2] = '{dir: 1'b0, count: 8'd0, period: 16'd7, abort_at: 0, done_cyc: 1, steps: 8'd0,
                ab: 1'b0};
    vecs[3] = '{dir: 1'b0, count: 8'd5, period: 16'd3, abort_at: 5, done_cyc: 6, steps: 8'd2,
                ab: 1'b1};
    vecs[4] = '{dir: 1'b1, count: 8'd4, period: 16'd2, abort_at: 3, done_cyc: 4, steps: 8'd2,
                ab: 1'b1};
    vecs[5] = '{dir: 1'b1, count: 8'd1, period: 16'd1, abort_at: 0, done_cyc: 2, steps: 8'd1,
                ab: 1'b0};
    vecs[6] = '{dir: 1'b0, count: 8'd2, period: 16'd1, abort_at: 0, done_cyc: 4, steps: 8'd2,
                ab: 1'b0};
    vecs[7] = '{dir: 1'b1, count: 8'd3, period: 16'd3, abort_at: 1, done_cyc: 2, steps: 8'd1,
                ab: 1'b1};

    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_count  = '0;
    cmd_period = '0;
    abort      = 1'b0;

    #23;
    chk("reset_outputs", {26'd0, horario, antihorario, busy, done, aborted, cmd_ready},
        32'h1);
    chk("reset_steps", {24'd0, steps_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // Table-driven whole commands.
    for (int v = 0; v < 8; v++) begin
      eff = (vecs[v].period < 16'd2) ? 2 : int'(vecs[v].period);
      send_cmd(vecs[v].dir, vecs[v].count, vecs[v].period);
      cmd_valid = 1'b0;
      for (int c = 1; c <= vecs[v].done_cyc + 1; c++) begin
        logic pulse;
        pulse = (c < vecs[v].done_cyc) && (((c - 1) % eff) == 0) &&
                (((c - 1) / eff) < int'(vecs[v].steps));
        exp_o = {pulse && !vecs[v].dir, pulse && vecs[v].dir, c < vecs[v].done_cyc,
                 c == vecs[v].done_cyc, c == vecs[v].done_cyc + 1,
                 (c >= vecs[v].done_cyc) ? vecs[v].ab : 1'b0};
        chk($sformatf("vec%0d_cyc%0d", v, c),
            {26'd0, horario, antihorario, busy, done, cmd_ready, aborted}, {26'd0, exp_o});
        abort = (c == vecs[v].abort_at);
        @(posedge clk);
        #1;
        if (c == vecs[v].done_cyc + 1) break;
      end
      abort = 1'b0;
      chk($sformatf("vec%0d_steps", v), {24'd0, steps_done}, {24'd0, vecs[v].steps});
    end

    // cmd_valid held through a busy command with changing fields: only the idle edge accepts.
    send_cmd(1'b0, 8'd2, 16'd2);
    cmd_dir    = 1'b1;
    cmd_count  = 8'd1;
    cmd_period = 16'd5;
    h_cnt = 0;
    a_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      if (horario) h_cnt++;
      if (antihorario) a_cnt++;
      chk($sformatf("hold_ready_low_cyc%0d", c), {31'd0, cmd_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("hold_h_pulses", h_cnt, 32'd2);
    chk("hold_a_pulses", a_cnt, 32'd0);
    chk("hold_idle_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("hold_second_pulse", {30'd0, horario, antihorario}, 32'd1);
    @(posedge clk);
    #1;
    chk("hold_second_done", {31'd0, done}, 32'd1);
    chk("hold_second_steps", {24'd0, steps_done}, 32'd1);
    @(posedge clk);
    #1;

    // Abort alone in IDLE is ignored; abort together with cmd_valid still accepts.
    abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_abort_cyc%0d", c), {29'd0, done, busy, cmd_ready}, 32'd1);
    end
    send_cmd(1'b0, 8'd1, 16'd0);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    chk("abort_valid_pulse", {29'd0, horario, antihorario, aborted}, 32'h4);
    @(posedge clk);
    #1;
    chk("abort_valid_done", {30'd0, done, aborted}, 32'h2);
    @(posedge clk);
    #1;

    // Reset during GAP of a count=4 command.
    send_cmd(1'b0, 8'd4, 16'd4);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_pre_gap", {29'd0, busy, horario, antihorario}, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {26'd0, horario, antihorario, busy, done, aborted, cmd_ready},
        32'h1);
    chk("rst_async_steps", {24'd0, steps_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_after_cyc%0d", c),
          {24'd0, steps_done, horario, antihorario, busy, done, aborted, cmd_ready}, 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
